// File: rtl/avg_thresh_det.sv
// avg_thresh_det: hysteresis threshold detector with hold qualification, event counter and peak capture (optional IRQ via AVG_THRESH_DET_IRQ_EN)
module avg_thresh_det #(
  parameter int DATA_W = 8,
  parameter int HOLD   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] thr_hi_i,
  input  logic [DATA_W-1:0] thr_lo_i,
  input  logic              en_i,
  input  logic              clr_i,
  output logic              above_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic [CNT_W-1:0]  event_cnt_o,
  output logic [DATA_W-1:0] peak_o
`ifdef AVG_THRESH_DET_IRQ_EN
  ,
  input  logic              irq_ack_i,
  output logic              irq_o
`endif
);
  typedef enum logic [1:0] {LOW, ARM, HIGH, DISARM} state_t;
  localparam logic [3:0] HOLD_N = 4'(HOLD);
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  state_t state_q, state_d;
  logic [3:0] hold_q, hold_d, hold_inc;
  logic signed [DATA_W-1:0] run_q, run_d, data_s, mx;
  logic signed [DATA_W-1:0] peak_q, peak_d;
  logic above_q, above_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic qh, ql, done;
  assign data_s   = data_i;
  assign qh       = data_s > $signed(thr_hi_i);
  assign ql       = data_s < $signed(thr_lo_i);
  assign mx       = run_q > data_s ? run_q : data_s;
  assign hold_inc = hold_q + 4'd1;
  assign done     = hold_inc == HOLD_N;
  // next state, hold counter, running max and edge pulses; everything holds while disabled
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    run_d   = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i) begin
      case (state_q)
        LOW: if (qh) begin
          run_d  = data_s;
          hold_d = 4'd1;
          if (HOLD_N == 4'd1) begin
            state_d = HIGH;
            hold_d  = 4'd0;
            rise_d  = 1'b1;
          end else state_d = ARM;
        end
        ARM: if (qh) begin
          run_d  = mx;
          hold_d = hold_inc;
          if (done) begin
            state_d = HIGH;
            hold_d  = 4'd0;
            rise_d  = 1'b1;
          end
        end else begin
          state_d = LOW;
          hold_d  = 4'd0;
          run_d   = MIN_V;
        end
        HIGH: begin
          run_d = mx;
          if (ql) begin
            hold_d = 4'd1;
            if (HOLD_N == 4'd1) begin
              state_d = LOW;
              hold_d  = 4'd0;
              run_d   = MIN_V;
              fall_d  = 1'b1;
            end else state_d = DISARM;
          end
        end
        DISARM: begin
          run_d = mx;
          if (ql) begin
            hold_d = hold_inc;
            if (done) begin
              state_d = LOW;
              hold_d  = 4'd0;
              run_d   = MIN_V;
              fall_d  = 1'b1;
            end
          end else begin
            state_d = HIGH;
            hold_d  = 4'd0;
          end
        end
        default: state_d = LOW;
      endcase
    end
  end
  // level, counter and peak next values; clear beats increment and peak load
  always_comb begin
    above_d = state_d == HIGH || state_d == DISARM;
    cnt_d   = clr_i ? '0 : (rise_d && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    peak_d  = clr_i ? '0 : fall_d ? mx : peak_q;
  end
  // registered state and outputs with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= LOW;
      hold_q  <= 4'd0;
      run_q   <= MIN_V;
      above_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
      above_q <= above_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
    end
  end
  assign above_o     = above_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign event_cnt_o = cnt_q;
  assign peak_o      = peak_q;
`ifdef AVG_THRESH_DET_IRQ_EN
  logic irq_q, irq_d;
  // sticky interrupt: set together with rise_o, set wins over acknowledge
  always_comb irq_d = rise_d ? 1'b1 : irq_ack_i ? 1'b0 : irq_q;
  // interrupt flag register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign irq_o = irq_q;
`endif
endmodule
